// File: rtl/mips_pkg.sv
// Shared MIPS instruction field positions, opcode/funct constants and the
// fetch-stage state type used by the fetch unit and its consumers.
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [5:0] RTYPE   = 6'h00;
    localparam logic [5:0] SYSCALL = 6'h0C;

    localparam int INST_BYTES = 4;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs one outstanding imem request at a time and
// hands words to the CU over valid/ready. Define FETCH_PERF_EN for perf counters.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] inst,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              fire;
    logic              load_inst;
    logic              drop_inst;
    logic              take_redirect;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign fire             = inst_valid && inst_ready;

    assign imem_req  = rst_b && (state == REQ);
    assign imem_addr = pc;
    assign opcode    = inst[OPCODE_MSB:OPCODE_LSB];
    assign funct     = inst[FUNCT_MSB:FUNCT_LSB];

    // A consumed SYSCALL outranks a redirect arriving in the same cycle.
    always_comb begin
        state_next    = state;
        load_inst     = 1'b0;
        drop_inst     = 1'b0;
        take_redirect = 1'b0;
        case (state)
            REQ: begin
                if (redirect) begin
                    take_redirect = 1'b1;
                    state_next    = imem_gnt ? DRAIN : REQ;
                end else if (imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    take_redirect = 1'b1;
                    state_next    = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    load_inst  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (fire && halted) begin
                    drop_inst  = 1'b1;
                    state_next = HALT;
                end else if (redirect) begin
                    take_redirect = 1'b1;
                    drop_inst     = 1'b1;
                    state_next    = REQ;
                end else if (fire) begin
                    drop_inst  = 1'b1;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                // The stale response still has to be absorbed before a new request.
                take_redirect = redirect;
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state      <= REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (take_redirect) begin
                pc <= redirect_aligned;
            end else if (load_inst) begin
                pc <= pc + ADDR_W'(INST_BYTES);
            end
            if (load_inst) begin
                inst       <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else if (drop_inst) begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else if (state != HALT) begin
            if (fire) begin
                perf_fetched <= sat_inc(perf_fetched);
            end
            if (state == REQ || state == WAIT || state == DRAIN) begin
                perf_stall <= sat_inc(perf_stall);
            end
        end
    end
`endif

endmodule
